// File: rtl/fetch_pkg.sv
// Shared types and default widths for the operand fetch block.
package fetch_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int SEL_W_DEF  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ_A = 2'd1,
        READ_B = 2'd2,
        HOLD   = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/operand_fetch_fwd_mux.sv
// Bypass select between bank read data and a same-cycle bank write.
// The bypass is present only when OPERAND_FETCH_FWD_EN is defined.
module fwd_mux #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 2
) (
    input  logic [DATA_W-1:0] rb_val,
    input  logic [SEL_W-1:0]  rd_sel,
    input  logic              wr_en,
    input  logic [SEL_W-1:0]  wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] val
);

`ifdef OPERAND_FETCH_FWD_EN
    logic hit;
    assign hit = wr_en && (wr_sel == rd_sel);
    assign val = hit ? wr_data : rb_val;
`else
    logic unused_wr;
    assign unused_wr = ^{wr_en, wr_sel, wr_data, rd_sel};
    assign val       = rb_val;
`endif

endmodule

// File: rtl/operand_fetch.sv
// Reads one or two source registers through the bank's single read port
// and presents them to the ALU stage. Bypass is built with OPERAND_FETCH_FWD_EN.
module operand_fetch
    import fetch_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int SEL_W  = SEL_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [SEL_W-1:0]  ra_sel,
    input  logic [SEL_W-1:0]  rb_sel,
    input  logic              need_b,
    output logic [SEL_W-1:0]  rb_rs,
    input  logic [DATA_W-1:0] rb_val,
    input  logic              wr_en,
    input  logic [SEL_W-1:0]  wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output fetch_state_e      state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both 1; valid holds its payload stable until that edge.

    logic [SEL_W-1:0]  b_sel;
    logic              need_b_q;
    logic [DATA_W-1:0] fwd_val;

    fwd_mux #(.DATA_W(DATA_W), .SEL_W(SEL_W)) u_fwd_mux (
        .rb_val  (rb_val),
        .rd_sel  (rb_rs),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_data (wr_data),
        .val     (fwd_val)
    );

    assign req_ready = (state == IDLE) & ~rst;

    // rb_rs is loaded one state ahead so it already points at the operand
    // being captured while in READ_A / READ_B.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_valid <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            rb_rs    <= '0;
            b_sel    <= '0;
            need_b_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        rb_rs    <= ra_sel;
                        b_sel    <= rb_sel;
                        need_b_q <= need_b;
                        state    <= READ_A;
                    end
                end
                READ_A: begin
                    op_a <= fwd_val;
                    if (!need_b_q) begin
                        op_b     <= '0;
                        op_valid <= 1'b1;
                        state    <= HOLD;
                    end else if (b_sel == rb_rs) begin
                        op_b     <= fwd_val;
                        op_valid <= 1'b1;
                        state    <= HOLD;
                    end else begin
                        rb_rs <= b_sel;
                        state <= READ_B;
                    end
                end
                READ_B: begin
                    op_b     <= fwd_val;
                    op_valid <= 1'b1;
                    state    <= HOLD;
                end
                HOLD: begin
                    if (op_ready) begin
                        op_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
